// File: rtl/line_feed_ctrl_pkg.sv
// Shared definitions for the line feed controller and its window-controller peer.
// Holds the FSM encoding, pixel width and default geometry constants.
// No logic lives here; consumers import it with line_feed_ctrl_pkg::*.
package line_feed_ctrl_pkg;

    localparam int PIX_W          = 8;
    localparam int DEF_LINE_W     = 512;
    localparam int DEF_IMG_LINES  = 512;
    localparam int DEF_PAD_LINES  = 1;
    localparam int DEF_INIT_LINES = 4;
    localparam int DEF_CRED_W     = 4;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/line_feed_ctrl_if.sv
// Pixel stream bundle: upstream ready/valid bytes in, pixel/valid stream out.
// The slave modport is the controller, the master modport is its environment.
// Purely structural; carries no state.
interface line_feed_ctrl_if;
    import line_feed_ctrl_pkg::*;

    pix_t i_s_data;
    logic i_s_valid;
    logic o_s_ready;
    pix_t o_pixel_data;
    logic o_pixel_data_valid;

    modport master (
        output i_s_data,
        output i_s_valid,
        input  o_s_ready,
        input  o_pixel_data,
        input  o_pixel_data_valid
    );

    modport slave (
        input  i_s_data,
        input  i_s_valid,
        output o_s_ready,
        output o_pixel_data,
        output o_pixel_data_valid
    );

endinterface

// File: rtl/line_credit_counter.sv
// Saturating line-credit counter with synchronous reload and a nonzero flag.
// Latency: load/inc/dec take effect on the next clock edge.
// No backpressure; inc and dec in the same cycle cancel out.
module line_credit_counter #(
    parameter int CRED_W = 4,
    parameter int INIT   = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nonzero
);

    localparam logic [CRED_W-1:0] CRED_MAX = '1;
    localparam logic [CRED_W-1:0] CRED_INI = CRED_W'(INIT);
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

    logic [CRED_W-1:0] credit_q;

    // Reload on frame start, otherwise count up/down clamped to [0, max].
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            credit_q <= CRED_INI;
        end else if (i_load) begin
            credit_q <= CRED_INI;
        end else if (i_inc && !i_dec) begin
            if (credit_q != CRED_MAX) begin
                credit_q <= credit_q + CRED_ONE;
            end
        end else if (i_dec && !i_inc) begin
            if (credit_q != '0) begin
                credit_q <= credit_q - CRED_ONE;
            end
        end
    end

    assign o_nonzero = (credit_q != '0);

endmodule

// File: rtl/line_feed_ctrl.sv
// Streams upstream bytes to the window controller, gated by line credits, then pads zero lines.
// Latency: one cycle from an upstream transfer (or a pad emit) to o_pixel_data_valid.
// Backpressure: o_s_ready drops only at a line boundary once credits run out; resumes on i_intr.
module line_feed_ctrl
    import line_feed_ctrl_pkg::*;
#(
    parameter  int LINE_W     = DEF_LINE_W,
    parameter  int IMG_LINES  = DEF_IMG_LINES,
    parameter  int PAD_LINES  = DEF_PAD_LINES,
    parameter  int INIT_LINES = DEF_INIT_LINES,
    parameter  int CRED_W     = DEF_CRED_W,
    localparam int LC_W       = $clog2(IMG_LINES + PAD_LINES + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_intr,
    line_feed_ctrl_if.slave     bus,
    output logic                o_busy,
    output logic                o_done,
    output logic [LC_W-1:0]     o_line_count
);

    localparam int PC_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    localparam logic [PC_W-1:0] PIX_LAST = PC_W'(LINE_W - 1);
    localparam logic [PC_W-1:0] PIX_ONE  = PC_W'(1);
    localparam logic [LC_W-1:0] LINE_ONE = LC_W'(1);
    localparam logic [LC_W-1:0] IMG_END  = LC_W'(IMG_LINES);
    localparam logic [LC_W-1:0] ALL_END  = LC_W'(IMG_LINES + PAD_LINES);

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pix_cnt_q;
    logic [LC_W-1:0] line_cnt_q;
    logic [LC_W-1:0] line_cnt_inc;
    pix_t            pix_dat_q;
    logic            pix_vld_q;

    logic            credit_nz;
    logic            s_ready;
    logic            start_frame;
    logic            xfer;
    logic            pad_emit;
    logic            emit;
    logic            line_end;

    line_credit_counter #(
        .CRED_W (CRED_W),
        .INIT   (INIT_LINES)
    ) u_credit (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (start_frame),
        .i_inc     (i_intr && (state_q != ST_IDLE)),
        .i_dec     (line_end),
        .o_nonzero (credit_nz)
    );

    // Per-cycle events: frame start, upstream transfer, pad emit and line end.
    always_comb begin
        start_frame  = (state_q == ST_IDLE) && i_start;
        xfer         = bus.i_s_valid && s_ready;
        pad_emit     = (state_q == ST_PAD) && credit_nz;
        emit         = xfer || pad_emit;
        line_end     = emit && (pix_cnt_q == PIX_LAST);
        line_cnt_inc = line_cnt_q + LINE_ONE;
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: phase changes only ever happen on a line end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (line_end && (line_cnt_inc == IMG_END)) begin
                    state_d = (PAD_LINES == 0) ? ST_DONE : ST_PAD;
                end
            end
            ST_PAD: begin
                if (line_end && (line_cnt_inc == ALL_END)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the registered state only.
    always_comb begin
        s_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_SEND: begin
                s_ready = credit_nz;
                o_busy  = 1'b1;
            end
            ST_PAD: begin
                o_busy  = 1'b1;
            end
            ST_DONE: begin
                o_done  = 1'b1;
            end
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

    // Pixel and line counters; the line count survives into IDLE until the next start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else if (start_frame) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else if (emit) begin
            pix_cnt_q <= line_end ? '0 : (pix_cnt_q + PIX_ONE);
            if (line_end) begin
                line_cnt_q <= line_cnt_inc;
            end
        end
    end

    // Registered pixel output; data holds its last value when nothing is emitted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_vld_q <= 1'b0;
            pix_dat_q <= '0;
        end else begin
            pix_vld_q <= emit;
            if (emit) begin
                pix_dat_q <= xfer ? bus.i_s_data : '0;
            end
        end
    end

    assign bus.o_s_ready          = s_ready;
    assign bus.o_pixel_data       = pix_dat_q;
    assign bus.o_pixel_data_valid = pix_vld_q;
    assign o_line_count           = line_cnt_q;

endmodule

// File: doc/line_feed_ctrl.md
Name: line_feed_ctrl

Overview:
- Transmit-side companion of the 3x3 window line-buffer controller.
- Pulls 8-bit greyscale pixels from an upstream byte stream (ready/valid) and emits them as a pixel/valid stream to the window controller.
- Uses line credits: starts with INIT_LINES credits and gains one credit per consumer interrupt, so the line buffers never overflow.
- After the last image line it appends PAD_LINES zero lines so the bottom rows of the image are flushed through the window.

Parameters:
LINE_W, 512, pixels per line
IMG_LINES, 512, image lines taken from the upstream stream
PAD_LINES, 1, zero lines appended after the image
INIT_LINES, 4, initial line credits (equals the number of consumer line buffers)
CRED_W, 4, credit counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  one-cycle pulse that starts a frame; ignored unless IDLE
i_s_data  in  8  upstream pixel
i_s_valid  in  1  upstream pixel valid
o_s_ready  out  1  upstream ready
o_pixel_data  out  8  pixel to the window controller
o_pixel_data_valid  out  1  pixel valid, one cycle per pixel
i_intr  in  1  consumer "line consumed" pulse
o_busy  out  1  high from the start pulse until DONE
o_done  out  1  one-cycle pulse at end of frame
o_line_count  out  $clog2(IMG_LINES+PAD_LINES+1)  lines fully sent in the current frame

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state=IDLE; credit=INIT_LINES; pixel and line counters 0; all outputs 0. No partial line survives a reset.
- States:
  - IDLE: on i_start go to SEND; credit reloaded to INIT_LINES; counters cleared; o_busy goes high the next cycle.
  - SEND: o_s_ready = (credit!=0), combinational from registered state. A transfer happens when i_s_valid & o_s_ready.
  - PAD: no upstream handshake (o_s_ready=0). Emits one zero pixel per cycle while credit!=0.
  - DONE: o_done=1 for exactly one cycle, o_busy=0; next state IDLE.
- Output timing: o_pixel_data and o_pixel_data_valid are registered, 1-cycle latency from the transfer (SEND) or the emit decision (PAD). Valid is low in any cycle without a transfer; data holds its last value.
- Pixel counter:
  - Increments on each emitted pixel and wraps at LINE_W-1 to 0.
  - On the wrap: line counter +1 and credit -1.
  - Leave SEND for PAD when line count reaches IMG_LINES; go straight to DONE if PAD_LINES=0.
  - Leave PAD for DONE when line count reaches IMG_LINES+PAD_LINES.
- Credits:
  - i_intr adds 1 credit in any state except IDLE.
  - i_intr coinciding with a line-end decrement: net change 0.
  - Credit saturates at 2^CRED_W-1 and never goes below 0.
  - A credit of 0 mid-line cannot occur, because credit is consumed at line end. Credit gating therefore happens only at line boundaries, and a line already started always completes once upstream data arrives.
- Upstream stall: SEND waits indefinitely with o_s_ready high. No timeout.
- i_start while busy: ignored, no effect on counters.
- o_line_count holds its final value in IDLE until the next i_start.

Decomposition:
- Shared package holds:
  - state encoding for IDLE/SEND/PAD/DONE as a 2-bit enum;
  - the pixel width of 8;
  - the default LINE_W/INIT_LINES constants, reused by the window controller.
- One sub-module, line_credit_counter: saturating up/down counter with a load input (INIT_LINES), an inc input (i_intr), a dec input (line end) and a nonzero flag. Everything else stays in the top-level module.

Test Plan:
1. LINE_W=8, IMG_LINES=6, PAD_LINES=1, INIT_LINES=4, upstream always valid, no i_intr -> exactly 32 pixels emitted, then o_s_ready=0, o_line_count=4, o_busy=1, no o_done.
2. Same setup, then one i_intr pulse per 10 cycles -> 56 pixels total: 48 image pixels in order, then 8 zero pixels; o_done pulses once; o_line_count=7.
3. i_intr asserted on the same cycle as the last pixel of line 0 -> credit stays 4; streaming continues without a gap.
4. Upstream i_s_valid toggling 1/0 every cycle -> each output pixel equals the accepted input, 1 cycle later; no duplicates or drops (scoreboard check).
5. i_rst asserted asynchronously mid-line 2 (between clock edges) -> outputs 0 immediately; after release, i_start restarts from pixel 0 with credit=4.
6. i_start pulsed while busy, and i_intr pulsed while IDLE -> both ignored; credit remains 4 when the next frame starts.
